// File: rtl/issue_scoreboard.sv
// In-order issue controller: holds one decoded instruction, stalls on RAW/WAW/in-flight hazards, issues with valid/ready.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets same-cycle writebacks clear hazards one cycle earlier.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_dec_valid,
  output logic                   o_dec_ready,
  input  logic [4:0]             i_rs1,
  input  logic                   i_rs1_used,
  input  logic [4:0]             i_rs2,
  input  logic                   i_rs2_used,
  input  logic [4:0]             i_rd,
  input  logic                   i_rd_used,
  output logic                   o_ex_valid,
  input  logic                   i_ex_ready,
  output logic [4:0]             o_ex_rs1,
  output logic [4:0]             o_ex_rs2,
  output logic [4:0]             o_ex_rd,
  output logic                   o_ex_rd_used,
  input  logic                   i_wb_valid,
  input  logic [4:0]             i_wb_rd,
  input  logic                   i_wb_rd_used,
  output logic [31:0]            o_busy,
  output logic [3:0]             o_inflight,
  output logic [STALL_CNT_W-1:0] o_stall_cycles,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_STALL = 2'd1,
    SB_ISSUE = 2'd2
  } sb_state_t;

  sb_state_t              state_reg;
  logic                   dec_ready_reg;
  logic                   ex_valid_reg;
  logic [4:0]             rs1_reg;
  logic [4:0]             rs2_reg;
  logic [4:0]             rd_reg;
  logic                   rs1_used_reg;
  logic                   rs2_used_reg;
  logic                   rd_used_reg;
  logic [31:0]            busy_reg;
  logic [3:0]             inflight_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  logic [31:0] wb_clr;
  logic [31:0] set_mask;
  logic [31:0] busy_eff;
  logic [31:0] busy_next;
  logic [3:0]  inflight_eff;
  logic [3:0]  inflight_next;
  logic        wb_dec;
  logic        handshake;
  logic        haz_in;
  logic        haz_held;

  function automatic logic hazard(
    input logic [4:0]  r1,
    input logic        u1,
    input logic [4:0]  r2,
    input logic        u2,
    input logic [4:0]  rd,
    input logic        ud,
    input logic [31:0] busy,
    input logic [3:0]  inflight
  );
    logic h;
    h = 1'b0;
    if (u1 && (r1 != 5'd0) && busy[r1]) h = 1'b1;
    if (u2 && (r2 != 5'd0) && busy[r2]) h = 1'b1;
    if (ud && (rd != 5'd0) && busy[rd]) h = 1'b1;
    if (inflight == 4'(MAX_INFLIGHT)) h = 1'b1;
    return h;
  endfunction

  always_comb begin
    wb_clr = '0;
    if (i_wb_valid && i_wb_rd_used) wb_clr = 32'd1 << i_wb_rd;
    wb_dec = i_wb_valid && (inflight_reg != 4'd0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    busy_eff     = busy_reg & ~wb_clr;
    inflight_eff = inflight_reg - {3'b000, wb_dec};
`else
    busy_eff     = busy_reg;
    inflight_eff = inflight_reg;
`endif

    haz_in   = hazard(i_rs1, i_rs1_used, i_rs2, i_rs2_used, i_rd, i_rd_used,
                      busy_eff, inflight_eff);
    haz_held = hazard(rs1_reg, rs1_used_reg, rs2_reg, rs2_used_reg, rd_reg, rd_used_reg,
                      busy_eff, inflight_eff);

    handshake = (state_reg == SB_ISSUE) && i_ex_ready;

    set_mask = '0;
    if (handshake && rd_used_reg && (rd_reg != 5'd0)) set_mask = 32'd1 << rd_reg;

    // Set is applied after clear so a same-register set/clear leaves the bit set.
    busy_next = ((busy_reg & ~wb_clr) | set_mask) & ~32'd1;

    inflight_next = inflight_reg;
    if (handshake && !wb_dec)      inflight_next = inflight_reg + 4'd1;
    else if (!handshake && wb_dec) inflight_next = inflight_reg - 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= SB_IDLE;
      dec_ready_reg <= 1'b1;
      ex_valid_reg  <= 1'b0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      rs1_used_reg  <= 1'b0;
      rs2_used_reg  <= 1'b0;
      rd_used_reg   <= 1'b0;
      busy_reg      <= '0;
      inflight_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      inflight_reg <= inflight_next;

      if ((state_reg == SB_STALL) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);

      case (state_reg)
        SB_IDLE: begin
          if (i_dec_valid) begin
            rs1_reg       <= i_rs1;
            rs2_reg       <= i_rs2;
            rd_reg        <= i_rd;
            rs1_used_reg  <= i_rs1_used;
            rs2_used_reg  <= i_rs2_used;
            rd_used_reg   <= i_rd_used;
            dec_ready_reg <= 1'b0;
            if (haz_in) begin
              state_reg <= SB_STALL;
            end else begin
              state_reg    <= SB_ISSUE;
              ex_valid_reg <= 1'b1;
            end
          end
        end
        SB_STALL: begin
          if (!haz_held) begin
            state_reg    <= SB_ISSUE;
            ex_valid_reg <= 1'b1;
          end
        end
        SB_ISSUE: begin
          if (i_ex_ready) begin
            state_reg     <= SB_IDLE;
            ex_valid_reg  <= 1'b0;
            dec_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= SB_IDLE;
          ex_valid_reg  <= 1'b0;
          dec_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_dec_ready    = dec_ready_reg;
  assign o_ex_valid     = ex_valid_reg;
  assign o_ex_rs1       = rs1_reg;
  assign o_ex_rs2       = rs2_reg;
  assign o_ex_rd        = rd_reg;
  assign o_ex_rd_used   = rd_used_reg;
  assign o_busy         = busy_reg;
  assign o_inflight     = inflight_reg;
  assign o_stall_cycles = stall_cnt_reg;
  assign o_state        = state_reg;

endmodule
